// File: rtl/fft_io_ctrl.sv
// ---------------------------------------------------------------------------
// fft_io_ctrl
// Frame-level I/O scheduler for the radix-4 FFT core. It collects one frame
// of N real samples from an input stream and writes them across the four
// external-port banks of RAM_A. It then pulses the core start and waits for
// a rising edge on the core ready level. Finally it streams the 17-bit
// results back out of RAM_A through a 2-entry skid FIFO with valid/ready
// flow control.
//
// Ports
//   iCLK, iRESET            clock, asynchronous active-low reset
//   iS_DATA/iS_VALID/oS_READY   input sample stream
//   oDATA/oADDR_WR/oWE      RAM_A write port (one bank per write, registered)
//   oADDR_RD                RAM_A read address, common to all banks
//   iDATA_RE_0..3           RAM_A bank read data, 1-cycle latency
//   oSTART/iRDY             core start pulse / core done level
//   oM_DATA/oM_VALID/oM_LAST/iM_READY   result output stream
//   oBUSY                   frame in progress
//   oERR                    sticky RUN-timeout flag
// ---------------------------------------------------------------------------
module fft_io_ctrl #(
    parameter int N       = 2048,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 65535
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [15:0]       iS_DATA,
    input  logic              iS_VALID,
    output logic              oS_READY,
    output logic [15:0]       oDATA,
    output logic [ADDR_W-1:0] oADDR_WR,
    output logic [3:0]        oWE,
    output logic [ADDR_W-1:0] oADDR_RD,
    input  logic [16:0]       iDATA_RE_0,
    input  logic [16:0]       iDATA_RE_1,
    input  logic [16:0]       iDATA_RE_2,
    input  logic [16:0]       iDATA_RE_3,
    output logic              oSTART,
    input  logic              iRDY,
    output logic [16:0]       oM_DATA,
    output logic              oM_VALID,
    output logic              oM_LAST,
    input  logic              iM_READY,
    output logic              oBUSY,
    output logic              oERR
);

    localparam int              CNT_W    = ADDR_W + 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
    localparam logic [15:0]     RUN_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_UNLOAD
    } state_t;

    state_t              r_state;
    logic                r_s_ready;
    logic [15:0]         r_data;
    logic [ADDR_W-1:0]   r_addr_wr;
    logic [3:0]          r_we;
    logic                r_start;
    logic                r_err;
    logic [CNT_W-1:0]    r_ld_cnt;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic                r_rd_done;
    logic [15:0]         r_run_cnt;
    logic                r_rdy_prev;

    // Read return stage: one read can be in flight (address presented this
    // cycle, data arrives next cycle).
    logic                r_d_vld;
    logic [1:0]          r_d_bank;
    logic                r_d_last;

    // 2-entry output FIFO
    logic [16:0]         r_fifo_data [2];
    logic                r_fifo_last [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_occ;

    logic                w_hs;
    logic                w_rdy_rise;
    logic                w_pop;
    logic                w_push;
    logic [2:0]          w_credit;
    logic                w_issue;
    logic [16:0]         w_ret_data;

    assign w_hs       = iS_VALID & r_s_ready;
    assign w_rdy_rise = iRDY & ~r_rdy_prev;
    assign w_pop      = oM_VALID & iM_READY;
    assign w_push     = r_d_vld;

    // A new read may go out when the FIFO can still take it after the
    // in-flight return lands. Counting this cycle's pop as a freed slot is
    // what sustains one result per cycle under continuous iM_READY.
    assign w_credit = {1'b0, r_occ} + {2'b00, r_d_vld};
    assign w_issue  = (r_state == S_UNLOAD) && !r_rd_done &&
                      (w_pop ? (w_credit < 3'd3) : (w_credit < 3'd2));

    always_comb begin
        w_ret_data = iDATA_RE_0;
        case (r_d_bank)
            2'd0:    w_ret_data = iDATA_RE_0;
            2'd1:    w_ret_data = iDATA_RE_1;
            2'd2:    w_ret_data = iDATA_RE_2;
            default: w_ret_data = iDATA_RE_3;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state    <= S_IDLE;
            r_s_ready  <= 1'b0;
            r_data     <= '0;
            r_addr_wr  <= '0;
            r_we       <= '0;
            r_start    <= 1'b0;
            r_err      <= 1'b0;
            r_ld_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_rd_done  <= 1'b0;
            r_run_cnt  <= '0;
            r_rdy_prev <= 1'b0;
            r_d_vld    <= 1'b0;
            r_d_bank   <= '0;
            r_d_last   <= 1'b0;
        end else begin
            r_rdy_prev <= iRDY;
            r_we       <= '0;
            r_start    <= 1'b0;

            // Sample n goes to bank n[1:0], word n[ADDR_W+1:2].
            if (w_hs) begin
                r_data    <= iS_DATA;
                r_addr_wr <= r_ld_cnt[CNT_W-1:2];
                r_we      <= 4'b0001 << r_ld_cnt[1:0];
                if (r_ld_cnt != LAST_IDX) begin
                    r_ld_cnt <= r_ld_cnt + CNT_W'(1);
                end
            end

            r_d_vld  <= w_issue;
            r_d_bank <= r_rd_cnt[1:0];
            r_d_last <= (r_rd_cnt == LAST_IDX);
            if (w_issue) begin
                if (r_rd_cnt == LAST_IDX) begin
                    r_rd_done <= 1'b1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_hs) begin
                        r_state <= S_LOAD;
                        r_err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_hs && (r_ld_cnt == LAST_IDX)) begin
                        r_state   <= S_START;
                        r_s_ready <= 1'b0;
                    end
                end
                S_START: begin
                    // The final write is on the bus during this state, so
                    // the start pulse appears on the following cycle.
                    r_start   <= 1'b1;
                    r_run_cnt <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (w_rdy_rise) begin
                        r_state <= S_UNLOAD;
                    end else if (r_run_cnt == RUN_LAST) begin
                        r_state   <= S_IDLE;
                        r_err     <= 1'b1;
                        r_s_ready <= 1'b1;
                        r_ld_cnt  <= '0;
                        r_rd_cnt  <= '0;
                        r_rd_done <= 1'b0;
                    end else begin
                        r_run_cnt <= r_run_cnt + 16'd1;
                    end
                end
                S_UNLOAD: begin
                    if (w_pop && oM_LAST) begin
                        r_state   <= S_IDLE;
                        r_s_ready <= 1'b1;
                        r_ld_cnt  <= '0;
                        r_rd_cnt  <= '0;
                        r_rd_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output FIFO. Push and pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_ret_data;
                r_fifo_last[r_wr_ptr] <= r_d_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign oS_READY = r_s_ready;
    assign oDATA    = r_data;
    assign oADDR_WR = r_addr_wr;
    assign oWE      = r_we;
    assign oADDR_RD = r_rd_cnt[CNT_W-1:2];
    assign oSTART   = r_start;
    assign oM_VALID = (r_occ != 2'd0);
    assign oM_DATA  = r_fifo_data[r_rd_ptr];
    assign oM_LAST  = oM_VALID & r_fifo_last[r_rd_ptr];
    assign oBUSY    = (r_state != S_IDLE);
    assign oERR     = r_err;

endmodule

// File: tb/tb_fft_io_ctrl.sv
module tb_fft_io_ctrl;

    localparam int N  = 2048;
    localparam int AW = 9;
    localparam int TO = 100;

    logic          iCLK = 1'b0;
    logic          iRESET = 1'b0;
    logic [15:0]   iS_DATA = '0;
    logic          iS_VALID = 1'b0;
    logic          oS_READY;
    logic [15:0]   oDATA;
    logic [AW-1:0] oADDR_WR;
    logic [3:0]    oWE;
    logic [AW-1:0] oADDR_RD;
    logic [16:0]   iDATA_RE_0 = '0;
    logic [16:0]   iDATA_RE_1 = '0;
    logic [16:0]   iDATA_RE_2 = '0;
    logic [16:0]   iDATA_RE_3 = '0;
    logic          oSTART;
    logic          iRDY = 1'b0;
    logic [16:0]   oM_DATA;
    logic          oM_VALID;
    logic          oM_LAST;
    logic          iM_READY = 1'b0;
    logic          oBUSY;
    logic          oERR;

    fft_io_ctrl #(.N(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .iCLK(iCLK), .iRESET(iRESET),
        .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
        .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE(oWE), .oADDR_RD(oADDR_RD),
        .iDATA_RE_0(iDATA_RE_0), .iDATA_RE_1(iDATA_RE_1),
        .iDATA_RE_2(iDATA_RE_2), .iDATA_RE_3(iDATA_RE_3),
        .oSTART(oSTART), .iRDY(iRDY),
        .oM_DATA(oM_DATA), .oM_VALID(oM_VALID), .oM_LAST(oM_LAST),
        .iM_READY(iM_READY), .oBUSY(oBUSY), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    // RAM model: bank b, word a returns 4*a+b one cycle after the address.
    logic [16:0] ram_base;
    assign ram_base = {6'b0, oADDR_RD, 2'b00};
    always @(posedge iCLK) begin
        iDATA_RE_0 <= ram_base | 17'd0;
        iDATA_RE_1 <= ram_base | 17'd1;
        iDATA_RE_2 <= ram_base | 17'd2;
        iDATA_RE_3 <= ram_base | 17'd3;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor state, sampled on the falling edge.
    int          cyc = 0;
    int          wr_cnt, wr_map_err, wr_timing_err, start_cnt, start_cyc, last_wr_cyc;
    int          beats, beat_err, last_cnt, stall_err, sready_err, run_cyc;
    int          first_beat_cyc, last_beat_cyc, rise_cyc;
    bit          after_start, prev_hs, prev_stall;
    logic [16:0] prev_data;
    logic        prev_last;
    logic [3:0]  we_log [N];
    logic [AW-1:0] addr_log [N];

    task automatic clr();
        wr_cnt = 0; wr_map_err = 0; wr_timing_err = 0; start_cnt = 0;
        start_cyc = 0; last_wr_cyc = 0; beats = 0; beat_err = 0; last_cnt = 0;
        stall_err = 0; sready_err = 0; run_cyc = 0; first_beat_cyc = 0;
        last_beat_cyc = 0; after_start = 0; prev_hs = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
    endtask

    always @(negedge iCLK) begin
        cyc++;
        if (iRESET) begin
            if (oWE != 4'b0) begin
                if (wr_cnt < N) begin
                    we_log[wr_cnt]   = oWE;
                    addr_log[wr_cnt] = oADDR_WR;
                    if (oWE != (4'b0001 << (wr_cnt % 4)) || oADDR_WR != wr_cnt / 4 ||
                        oDATA != wr_cnt)
                        wr_map_err++;
                end
                wr_cnt++;
                last_wr_cyc = cyc;
                if (!prev_hs) wr_timing_err++;
                if (wr_cnt == N && oS_READY) sready_err++;
            end else if (prev_hs) begin
                wr_timing_err++;
            end
            prev_hs = iS_VALID && oS_READY;

            if (oSTART) begin
                start_cnt++;
                start_cyc   = cyc;
                after_start = 1;
            end
            if (!oBUSY) after_start = 0;
            if (after_start) begin
                run_cyc++;
                if (oS_READY) sready_err++;
            end

            if (prev_stall && (!oM_VALID || oM_DATA != prev_data || oM_LAST != prev_last))
                stall_err++;
            if (oM_VALID && iM_READY) begin
                if (beats == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                if (oM_DATA != beats) beat_err++;
                if (oM_LAST != (beats == N - 1)) beat_err++;
                if (oM_LAST) last_cnt++;
                beats++;
            end
            prev_stall = oM_VALID && !iM_READY;
            prev_data  = oM_DATA;
            prev_last  = oM_LAST;
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Ramp load n = 0..N-1; optional random gaps; optional reset at abort_at.
    task automatic load_frame(input bit gaps, input int abort_at, input bit chk_err_clear);
        int n = 0;
        int guard = 0;
        bit hs;
        while (n < N && guard < 20000) begin
            iS_VALID = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            iS_DATA  = 16'(n);
            hs = iS_VALID && oS_READY;
            tick();
            guard++;
            if (hs) begin
                n++;
                if (chk_err_clear && n == 1) check("err_cleared", oERR, 0);
                if (n == abort_at) begin
                    iS_VALID = 1'b0;
                    iRESET   = 1'b0;
                    #1;
                    check("abort_we", oWE, 0);
                    check("abort_busy", oBUSY, 0);
                    check("abort_sready", oS_READY, 0);
                    check("abort_start", oSTART, 0);
                    check("abort_valid", oM_VALID, 0);
                    check("abort_data_addr", {oDATA, oADDR_WR, oADDR_RD}, 0);
                    return;
                end
            end
        end
        iS_VALID = 1'b0;
        if (n < N) check("load_bound", n, N);
    endtask

    task automatic run_and_unload(input bit rdy_rise, input bit rand_ready);
        int g = 0;
        while (!oSTART && g < 100) begin
            tick();
            g++;
        end
        if (!oSTART) check("start_bound", 0, 1);
        if (rdy_rise) begin
            repeat (20) tick();
            iRDY = 1'b0;
            repeat (40) tick();
            iRDY = 1'b1;
            rise_cyc = cyc;
        end
        g = 0;
        while (oBUSY && g < 12000) begin
            iM_READY = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            tick();
            g++;
        end
        iM_READY = 1'b0;
        if (oBUSY) check("idle_bound", oBUSY, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        // Reset state
        repeat (3) tick();
        check("rst_sready", oS_READY, 0);
        check("rst_we", oWE, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_err", oERR, 0);
        check("rst_mvalid", oM_VALID, 0);
        iRESET = 1'b1;
        #1;
        check("sready_before_clk", oS_READY, 0);
        tick();
        check("sready_after_clk", oS_READY, 1);

        // Frame 1: continuous load, stale-high iRDY, full-throughput unload
        clr();
        iRDY = 1'b1;
        load_frame(0, 0, 0);
        run_and_unload(1, 0);
        check("f1_wr_cnt", wr_cnt, N);
        check("f1_wr_map", wr_map_err, 0);
        check("f1_we5", we_log[5], 4'b0010);
        check("f1_addr5", addr_log[5], 1);
        check("f1_we2047", we_log[N-1], 4'b1000);
        check("f1_addr2047", addr_log[N-1], 511);
        check("f1_wr_timing", wr_timing_err, 0);
        check("f1_start_cnt", start_cnt, 1);
        check("f1_start_delay", start_cyc - last_wr_cyc, 1);
        check("f1_sready_busy", sready_err, 0);
        check("f1_stale_rdy", first_beat_cyc > rise_cyc, 1);
        check("f1_beats", beats, N);
        check("f1_beat_order", beat_err, 0);
        check("f1_last_cnt", last_cnt, 1);
        check("f1_throughput", last_beat_cyc - first_beat_cyc, N - 1);

        // Frame 2: random input gaps, random downstream stalls
        clr();
        load_frame(1, 0, 0);
        run_and_unload(1, 1);
        check("f2_wr_cnt", wr_cnt, N);
        check("f2_wr_map", wr_map_err, 0);
        check("f2_wr_timing", wr_timing_err, 0);
        check("f2_start_cnt", start_cnt, 1);
        check("f2_beats", beats, N);
        check("f2_beat_order", beat_err, 0);
        check("f2_stall_stable", stall_err, 0);
        check("f2_last_cnt", last_cnt, 1);

        // Frame 3: iRDY never rises, RUN times out
        clr();
        iRDY = 1'b0;
        load_frame(0, 0, 0);
        run_and_unload(0, 0);
        check("f3_run_cycles", run_cyc, TO);
        check("f3_err", oERR, 1);
        check("f3_busy", oBUSY, 0);
        check("f3_beats", beats, 0);

        // Frame 4: first sample clears oERR, reset at sample 700, fresh frame
        clr();
        load_frame(0, 700, 1);
        repeat (3) tick();
        iRESET = 1'b1;
        tick();
        clr();
        iRDY = 1'b1;
        load_frame(0, 0, 0);
        run_and_unload(1, 0);
        check("f4_wr_cnt", wr_cnt, N);
        check("f4_we0", we_log[0], 4'b0001);
        check("f4_addr0", addr_log[0], 0);
        check("f4_wr_map", wr_map_err, 0);
        check("f4_start_cnt", start_cnt, 1);
        check("f4_beats", beats, N);
        check("f4_beat_order", beat_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
